// File: rtl/ws2812_write_arbiter.sv
// Shares the ws2812 driver's LED-store write port between round-robin requesters
// and a fill sequencer that paints every LED with one colour and always wins.
module ws2812_write_arbiter #(
  parameter int NUM_LEDS = 8,
  parameter int NUM_REQ  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_led,
  input  logic [24*NUM_REQ-1:0]   req_rgb,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    fill_start,
  input  logic [23:0]             fill_rgb,
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic                    range_err,
  output logic                    write,
  output logic [7:0]              led_num,
  output logic [23:0]             rgb_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAST_IDX  = 8'(NUM_LEDS - 1);
  localparam logic [8:0] LED_LIMIT = 9'(NUM_LEDS);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_grant, last_grant_nx;
  logic [7:0]      idx, idx_nx;
  logic [23:0]     fill_color, color_nx;
  logic            write_nx, done_nx, err_nx;
  logic [7:0]      led_nx;
  logic [23:0]     rgb_nx;

  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic [7:0]         sel_led;
  logic [23:0]        sel_rgb;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    int cand;
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_led   = '0;
    sel_rgb   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_vec[cand] = 1'b1;
        grant_idx       = IW'(cand);
        sel_led         = req_led[cand*8 +: 8];
        sel_rgb         = req_rgb[cand*24 +: 24];
      end
    end
  end

  assign req_ready = (state == IDLE && !fill_start) ? grant_vec : '0;
  assign fill_busy = (state == FILL);

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    idx_nx        = idx;
    color_nx      = fill_color;
    write_nx      = 1'b0;
    led_nx        = led_num;
    rgb_nx        = rgb_data;
    done_nx       = 1'b0;
    err_nx        = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          write_nx = 1'b1;
          led_nx   = 8'd0;
          rgb_nx   = fill_rgb;
          color_nx = fill_rgb;
          idx_nx   = 8'd1;
          if (NUM_LEDS > 1) state_nx = FILL;
          else              done_nx  = 1'b1;
        end else if (grant_any) begin
          last_grant_nx = grant_idx;
          // Out-of-range indices are consumed but never forwarded to the driver.
          if ({1'b0, sel_led} >= LED_LIMIT) begin
            err_nx = 1'b1;
          end else begin
            write_nx = 1'b1;
            led_nx   = sel_led;
            rgb_nx   = sel_rgb;
          end
        end
      end
      FILL: begin
        write_nx = 1'b1;
        led_nx   = idx;
        rgb_nx   = fill_color;
        idx_nx   = idx + 8'd1;
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      idx        <= 8'd0;
      fill_color <= 24'd0;
      write      <= 1'b0;
      led_num    <= 8'd0;
      rgb_data   <= 24'd0;
      fill_done  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      idx        <= idx_nx;
      fill_color <= color_nx;
      write      <= write_nx;
      led_num    <= led_nx;
      rgb_data   <= rgb_nx;
      fill_done  <= done_nx;
      range_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Self-checking bench for ws2812_write_arbiter (NUM_LEDS=8, NUM_REQ=2) with a
// round-robin reference model and directed fill/range/reset scenarios.
module tb_ws2812_write_arbiter;

  localparam int NL = 8;
  localparam int NR = 2;

  logic          clk;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [15:0]   req_led;
  logic [47:0]   req_rgb;
  logic [NR-1:0] req_ready;
  logic          fill_start;
  logic [23:0]   fill_rgb;
  logic          fill_busy, fill_done, range_err, write;
  logic [7:0]    led_num;
  logic [23:0]   rgb_data;

  int checks   = 0;
  int failures = 0;
  int mp;  // model: index of last granted requester

  ws2812_write_arbiter #(.NUM_LEDS(NL), .NUM_REQ(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_led(req_led), .req_rgb(req_rgb), .req_ready(req_ready),
    .fill_start(fill_start), .fill_rgb(fill_rgb),
    .fill_busy(fill_busy), .fill_done(fill_done), .range_err(range_err),
    .write(write), .led_num(led_num), .rgb_data(rgb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pick: first valid requester after the last granted one, with wrap.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] l0, input logic [23:0] c0,
                       input logic [7:0] l1, input logic [23:0] c1,
                       input logic fs, input logic [23:0] fc);
    @(negedge clk);
    req_valid  = v;
    req_led    = {l1, l0};
    req_rgb    = {c1, c0};
    fill_start = fs;
    fill_rgb   = fc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = '0; req_led = '0; req_rgb = '0;
    fill_start = 1'b0; fill_rgb = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({write, led_num, rgb_data, fill_busy, fill_done, range_err, req_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got w=%b led=%h rgb=%h busy=%b done=%b err=%b rdy=%b expected all 0",
               write, led_num, rgb_data, fill_busy, fill_done, range_err, req_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mp = NR - 1;
  endtask

  task automatic test_alternate;
    logic [1:0] exp_gr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0]  l;
    logic [23:0] c;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 8'd3, 24'hFF0000, 8'd5, 24'h00FF00, 1'b0, 24'h0);
      checks++;
      if (req_ready !== exp_gr[i] || rr_pick(2'b11, mp) != ((exp_gr[i] == 2'b01) ? 0 : 1)) begin
        failures++;
        $display("[TB] FAIL alt_grant[%0d]: got %b expected %b", i, req_ready, exp_gr[i]);
      end
      mp = rr_pick(2'b11, mp);
      l = (mp == 0) ? 8'd3 : 8'd5;
      c = (mp == 0) ? 24'hFF0000 : 24'h00FF00;
      tick();
      checks++;
      if (write !== 1'b1 || led_num !== l || rgb_data !== c) begin
        failures++;
        $display("[TB] FAIL alt_write[%0d]: got w=%b led=%0d rgb=%h expected w=1 led=%0d rgb=%h",
                 i, write, led_num, rgb_data, l, c);
      end
    end
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b0, 24'h0);
    tick();
    checks++;
    if (write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL alt_idle: got write=%b expected 0", write);
    end
  endtask

  task automatic test_single;
    drive(2'b10, 8'd0, 24'h0, 8'd7, 24'h123456, 1'b0, 24'h0);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_grant: got %b expected 10", req_ready);
    end
    mp = 1;
    tick();
    checks++;
    if (write !== 1'b1 || led_num !== 8'd7 || rgb_data !== 24'h123456) begin
      failures++;
      $display("[TB] FAIL single_write: got w=%b led=%0d rgb=%h expected w=1 led=7 rgb=123456",
               write, led_num, rgb_data);
    end
    drive(2'b00, 8'd0, 24'h0, 8'd7, 24'h123456, 1'b0, 24'h0);
    tick();
    checks++;
    if (write !== 1'b0 || led_num !== 8'd7 || rgb_data !== 24'h123456) begin
      failures++;
      $display("[TB] FAIL single_after: got w=%b led=%0d rgb=%h expected w=0 led=7 rgb=123456",
               write, led_num, rgb_data);
    end
  endtask

  task automatic test_fill;
    drive(2'b01, 8'd2, 24'hABCDEF, 8'd0, 24'h0, 1'b1, 24'h0000FF);
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL fill_ready_k: got %b expected 00", req_ready);
    end
    tick();
    for (int c = 1; c <= NL; c++) begin
      checks++;
      if (write !== 1'b1 || led_num !== 8'(c - 1) || rgb_data !== 24'h0000FF ||
          fill_busy !== (c < NL) || fill_done !== (c == NL)) begin
        failures++;
        $display("[TB] FAIL fill_write[k+%0d]: got w=%b led=%0d rgb=%h busy=%b done=%b expected w=1 led=%0d rgb=0000ff busy=%b done=%b",
                 c, write, led_num, rgb_data, fill_busy, fill_done, c - 1, c < NL, c == NL);
      end
      drive(2'b01, 8'd2, 24'hABCDEF, 8'd0, 24'h0, 1'b0, 24'h0);
      checks++;
      if (req_ready !== ((c == NL) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("[TB] FAIL fill_ready[k+%0d]: got %b expected %b", c, req_ready,
                 (c == NL) ? 2'b01 : 2'b00);
      end
      tick();
    end
    mp = rr_pick(2'b01, mp);
    checks++;
    if (write !== 1'b1 || led_num !== 8'd2 || rgb_data !== 24'hABCDEF || fill_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_resume: got w=%b led=%0d rgb=%h done=%b expected w=1 led=2 rgb=abcdef done=0",
               write, led_num, rgb_data, fill_done);
    end
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b0, 24'h0);
    tick();
  endtask

  task automatic test_range;
    drive(2'b10, 8'd0, 24'h0, 8'd8, 24'h777777, 1'b0, 24'h0);
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL range_ready: got %b expected 10", req_ready);
    end
    mp = 1;
    tick();
    checks++;
    if (range_err !== 1'b1 || write !== 1'b0 || led_num !== 8'd2 || rgb_data !== 24'hABCDEF) begin
      failures++;
      $display("[TB] FAIL range_err: got err=%b w=%b led=%0d rgb=%h expected err=1 w=0 led=2 rgb=abcdef",
               range_err, write, led_num, rgb_data);
    end
    drive(2'b11, 8'd1, 24'h111111, 8'd4, 24'h444444, 1'b0, 24'h0);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL range_ptr: got %b expected 01", req_ready);
    end
    mp = 0;
    tick();
    checks++;
    if (range_err !== 1'b0 || write !== 1'b1 || led_num !== 8'd1 || rgb_data !== 24'h111111) begin
      failures++;
      $display("[TB] FAIL range_next: got err=%b w=%b led=%0d rgb=%h expected err=0 w=1 led=1 rgb=111111",
               range_err, write, led_num, rgb_data);
    end
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b0, 24'h0);
    tick();
  endtask

  task automatic test_fill_restart;
    int writes = 0;
    int dones  = 0;
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b1, 24'h00AA00);
    tick();
    for (int c = 1; c <= NL + 4; c++) begin
      if (write) writes++;
      if (fill_done) dones++;
      drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, (c == 3), 24'hFFFFFF);
      tick();
    end
    checks++;
    if (writes != NL || dones != 1) begin
      failures++;
      $display("[TB] FAIL fill_restart: got writes=%0d dones=%0d expected writes=%0d dones=1",
               writes, dones, NL);
    end
  endtask

  task automatic test_reset_midfill;
    int bad = 0;
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b1, 24'h5A5A5A);
    tick();
    drive(2'b00, 8'd0, 24'h0, 8'd0, 24'h0, 1'b0, 24'h0);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({write, led_num, rgb_data, fill_busy, fill_done, range_err} !== '0) begin
      failures++;
      $display("[TB] FAIL midfill_reset: got w=%b led=%h rgb=%h busy=%b done=%b err=%b expected all 0",
               write, led_num, rgb_data, fill_busy, fill_done, range_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mp = NR - 1;
    for (int c = 0; c < NL + 4; c++) begin
      tick();
      if (write !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL midfill_after: got %0d cycles with activity expected 0", bad);
    end
  endtask

  task automatic test_random;
    logic [1:0]  v;
    logic [7:0]  l0, l1, el;
    logic [23:0] c0, c1, ec;
    logic [7:0]  hold_led = 8'd0;
    logic [23:0] hold_rgb = 24'd0;
    logic        ew, ee;
    int          p;
    for (int n = 0; n < 200; n++) begin
      v  = 2'($urandom);
      l0 = 8'($urandom_range(0, 9));
      l1 = 8'($urandom_range(0, 9));
      c0 = 24'($urandom);
      c1 = 24'($urandom);
      drive(v, l0, c0, l1, c1, 1'b0, 24'h0);
      p = rr_pick(v, mp);
      checks++;
      if (req_ready !== ((p < 0) ? 2'b00 : 2'(1 << p))) begin
        failures++;
        $display("[TB] FAIL rand_grant[%0d]: got %b expected pick %0d", n, req_ready, p);
      end
      ew = 1'b0; ee = 1'b0;
      if (p >= 0) begin
        mp = p;
        el = (p == 0) ? l0 : l1;
        ec = (p == 0) ? c0 : c1;
        if (el >= NL) ee = 1'b1;
        else begin
          ew = 1'b1; hold_led = el; hold_rgb = ec;
        end
      end
      tick();
      checks++;
      if (write !== ew || range_err !== ee || led_num !== hold_led || rgb_data !== hold_rgb) begin
        failures++;
        $display("[TB] FAIL rand_out[%0d]: got w=%b err=%b led=%0d rgb=%h expected w=%b err=%b led=%0d rgb=%h",
                 n, write, range_err, led_num, rgb_data, ew, ee, hold_led, hold_rgb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_fill();
    test_range();
    test_fill_restart();
    test_reset_midfill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_write_arbiter.md
Name: ws2812_write_arbiter

Overview:
- Sits in front of the ws2812 driver's LED-store write port (`write`, `led_num`, `rgb_data`), which has a single writer.
- Shares that port between NUM_REQ independent requesters using round-robin arbitration with a valid/ready handshake.
- Also provides a fill sequencer that writes one colour to every LED, one LED per cycle; fill has absolute priority.
- All outputs are registered and connect directly to the driver.

Parameters:
- NUM_LEDS, 8: LED count of the attached driver; legal range 1..256.
- NUM_REQ, 2: number of requesters; legal range 1..8.

Ports:
- clk  in  1  system clock, same domain as driver
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_led  in  8*NUM_REQ  LED index, requester i at bits [8i+7:8i]
- req_rgb  in  24*NUM_REQ  colour, requester i at bits [24i+23:24i]
- req_ready  out  NUM_REQ  grant; transfer occurs when valid and ready are both high
- fill_start  in  1  single-cycle fill command
- fill_rgb  in  24  fill colour, sampled with fill_start
- fill_busy  out  1  fill sequence in progress
- fill_done  out  1  one-cycle pulse coincident with the last fill write
- range_err  out  1  one-cycle pulse: an accepted request had req_led >= NUM_LEDS
- write  out  1  driver write strobe
- led_num  out  8  driver LED index
- rgb_data  out  24  driver colour

Behaviour:
- Reset (async assert, sync release):
  - write=0, led_num=0, rgb_data=0, fill_busy=0, fill_done=0, range_err=0.
  - State=IDLE; round-robin pointer set so requester 0 has highest priority.
- States: IDLE, FILL.
- req_ready is combinational. It is all-zero in FILL, and all-zero in IDLE whenever fill_start=1.
- Otherwise, in IDLE, at most one bit is set: the first requester with valid=1, searching upward (with wrap) from last_grant+1.
- On a transfer from requester i:
  - last_grant<=i.
  - Next cycle: write=1, led_num=req_led[i], rgb_data=req_rgb[i]. Latency is exactly 1 cycle.
- Out-of-range index (req_led >= NUM_LEDS):
  - The request is still accepted (ready high, pointer advances), but write stays 0 and range_err=1 for one cycle.
  - No out-of-range index ever reaches the driver.
- Without a transfer: write=0. led_num/rgb_data hold their previous values.
- Fill accepted when fill_start=1 in IDLE (edge k):
  - Outputs load write=1, led_num=0, rgb_data=fill_rgb; the colour is latched internally; idx<=1.
  - If NUM_LEDS>1, state<=FILL.
- FILL, each cycle: write=1, led_num=idx, rgb_data=latched colour, idx++.
  - When loading idx==NUM_LEDS-1: state<=IDLE.
- fill_done=1 in the same cycle as the final write (k+NUM_LEDS).
  - With NUM_LEDS=1 this is k+1, and FILL is never entered.
- fill_busy=1 exactly while state==FILL (cycles k+1..k+NUM_LEDS-1).
- fill_start during FILL is ignored; there is no restart and no queuing.
- Requests are not accepted during FILL. Requesters must hold valid and data stable until ready.
- Requests can resume in cycle k+NUM_LEDS. Their write appears at k+NUM_LEDS+1, so writes are back-to-back with no gap and no overlap.
- The round-robin pointer is unchanged by fill.
- Async reset mid-fill: the fill is aborted immediately, all outputs go to reset values, and no further fill writes occur.
- Throughput: one driver write per cycle maximum, from either source.

Test Plan:
- Post-reset, req_valid=2'b11, led0=3/rgb0=FF0000, led1=5/rgb1=00FF00, both held 4 cycles:
  - grants alternate 01,10,01,10;
  - write pulses each cycle after the first with (3,FF0000),(5,00FF00),(3,FF0000),(5,00FF00).
- Single requester 1, led=7, rgb=123456, one cycle:
  - req_ready=2'b10 same cycle;
  - next cycle write=1, led_num=7, rgb_data=123456;
  - write=0 the cycle after.
- fill_start with fill_rgb=0000FF, NUM_LEDS=8, while req_valid=01 is held:
  - req_ready=0 cycles k..k+7;
  - write=1 with led_num 0..7 on cycles k+1..k+8, all 0000FF;
  - fill_done at k+8; fill_busy k+1..k+7;
  - requester granted at k+8, its write at k+9.
- Request with led=8 (NUM_LEDS=8):
  - ready=1 and accepted;
  - next cycle range_err=1, write=0;
  - the pointer still advances, checked by a following two-requester sequence.
- fill_start repeated at k+3 during fill: ignored; exactly 8 writes occur and one fill_done.
- reset_n low at k+4 during fill: outputs immediately 0; after release, write stays 0 and fill_busy=0 with no new stimulus.
